// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//
// Shares the single write port of one synchronous fifo between NUM_REQ producers.
// Arbitration is round-robin with packet-atomic grants. The owner keeps the port
// until its req_last beat is accepted, or until MAX_BURST beats have gone through.
// Every release is followed by a one-cycle arbitration bubble in IDLE.
//
// Optional feature (macro FIFO_ARB_TIMEOUT_EN): a granted requester that holds
// req_valid low for TIMEOUT_CYCLES consecutive cycles loses its grant. abort pulses
// for one cycle when that happens. Without the macro abort is tied low and the
// grant is held indefinitely.
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   synchronous, active-high
//   req_valid      in   [NUM_REQ]        per-requester beat valid
//   req_data       in   [NUM_REQ*WIDTH]  requester i at bits [i*WIDTH +: WIDTH]
//   req_last       in   [NUM_REQ]        final beat of a packet
//   req_ready      out  [NUM_REQ]        beat accepted when valid && ready
//   fifo_in_shift  out  fifo write strobe
//   fifo_in_data   out  [WIDTH]          fifo write data, 0 when no grant
//   fifo_in_full   in   fifo full flag, stalls the current burst
//   grant_valid    out  a requester owns the port
//   grant_id       out  [IDW]            index of the owner (holds after release)
//   burst_beats    out  [BBW]            beats accepted in the current grant
//   abort          out  one-cycle pulse when a grant is revoked by timeout

module fifo_write_arbiter #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned BBW = $clog2(MAX_BURST + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_in_shift,
  output logic [WIDTH-1:0]         fifo_in_data,
  input  logic                     fifo_in_full,
  output logic                     grant_valid,
  output logic [IDW-1:0]           grant_id,
  output logic [BBW-1:0]           burst_beats,
  output logic                     abort
);

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BBW-1:0] burst_beats_q, burst_beats_d;

  logic [IDW-1:0]   winner;
  logic             found;
  logic             any_valid;
  logic             active;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             cap_hit;
  logic             release_grant;
  logic             timeout;

  // Combinational outputs are gated by reset so the port is quiet for the whole
  // reset window, not only after the first reset edge.
  assign active    = (state_q == StBurst) && !reset;
  assign any_valid = |req_valid;

  // Select the owner's request signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin search: first valid requester after the last winner, with wrap.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] && (j == (32'(rr_ptr_q) + k) % NUM_REQ)) begin
          found  = 1'b1;
          winner = IDW'(j);
        end
      end
    end
  end

  assign accept  = active && !fifo_in_full && sel_valid;
  // The beat being accepted now is the MAX_BURST-th of this grant.
  assign cap_hit = (32'(burst_beats_q) + 32'd1 == MAX_BURST);

  assign release_grant = (accept && (sel_last || cap_hit)) || timeout;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TCW-1:0] idle_cnt_q, idle_cnt_d;

  // idle_cnt_q holds the number of earlier idle cycles, so the current cycle is the
  // TIMEOUT_CYCLES-th idle one when the count is one short of the limit.
  assign timeout = active && !sel_valid && (32'(idle_cnt_q) + 32'd1 == TIMEOUT_CYCLES);

  // Any cycle with valid high (stalled by full or not) restarts the count.
  always_comb begin
    idle_cnt_d = idle_cnt_q + 1'b1;
    if (!active || sel_valid || timeout) begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_id_q    <= '0;
      rr_ptr_q      <= IDW'(NUM_REQ - 1);
      burst_beats_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_beats_q <= burst_beats_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    burst_beats_d = burst_beats_q;
    case (state_q)
      StIdle: begin
        // req_last is deliberately ignored here; it only matters on accepted beats.
        if (any_valid) begin
          state_d       = StBurst;
          grant_id_d    = winner;
          burst_beats_d = '0;
        end
      end
      StBurst: begin
        if (release_grant) begin
          // grant_id keeps the old owner; rr_ptr remembers it for the next search.
          state_d       = StIdle;
          rr_ptr_d      = grant_id_q;
          burst_beats_d = '0;
        end else if (accept) begin
          burst_beats_d = burst_beats_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    grant_valid   = active;
    grant_id      = grant_id_q;
    burst_beats   = burst_beats_q;
    fifo_in_shift = accept;
    fifo_in_data  = active ? sel_data : '0;
    abort         = timeout;
    req_ready     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = active && !fifo_in_full && (grant_id_q == IDW'(i));
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (WIDTH=8, NUM_REQ=4, MAX_BURST=4).
// Each requester is fed from a small beat list; a beat is retired when it was seen
// accepted (valid && ready) at the preceding negedge. Expected values are hand-derived.

module tb_fifo_write_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned MB = 4;
  localparam int unsigned TO = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_in_shift;
  logic [W-1:0]   fifo_in_data;
  logic           fifo_in_full;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic [2:0]     burst_beats;
  logic           abort;

  fifo_write_arbiter #(
    .WIDTH         (W),
    .NUM_REQ       (N),
    .MAX_BURST     (MB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_in_shift(fifo_in_shift),
    .fifo_in_data (fifo_in_data),
    .fifo_in_full (fifo_in_full),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .burst_beats  (burst_beats),
    .abort        (abort)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] pd [N][16];
  logic       pl [N][16];
  int         head [N];
  int         tail [N];

  logic       s_shift, s_gv, s_abort;
  logic [7:0] s_data;
  logic [1:0] s_gid;
  logic [2:0] s_bb;
  logic [3:0] s_ready;

  task automatic push(input int i, input logic [7:0] d, input logic l);
    pd[i][tail[i]] = d;
    pl[i][tail[i]] = l;
    tail[i]++;
  endtask

  task automatic drive_heads();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = pd[i][head[i]];
        req_last[i]        = pl[i][head[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, retire accepted beats, drive the next heads.
  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clock);
    s_shift = fifo_in_shift;
    s_data  = fifo_in_data;
    s_gid   = grant_id;
    s_gv    = grant_valid;
    s_bb    = burst_beats;
    s_ready = req_ready;
    s_abort = abort;
    acc     = req_valid & req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) head[i]++;
    end
    drive_heads();
  endtask

  task automatic test_reset();
    cycle();  // first reset edge; state is defined from here on
    for (int c = 0; c < 2; c++) begin
      cycle();
      checks++;
      if ({s_gv, s_shift, s_ready, s_abort, s_bb, s_gid, s_data} !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs c%0d: got gv=%b shift=%b ready=%b abort=%b bb=%0d gid=%0d data=%h required all 0",
                 c, s_gv, s_shift, s_ready, s_abort, s_bb, s_gid, s_data);
      end
    end
    reset = 1'b0;
    cycle();  // IDLE arbitrates
    checks++;
    if (s_gv !== 1'b0 || s_shift !== 1'b0) begin
      errors++;
      $display("FAIL reset_arb_cycle: got gv=%b shift=%b required 0 0", s_gv, s_shift);
    end
    cycle();  // requester 0 owns the port
    checks++;
    if (s_gv !== 1'b1 || s_gid !== 2'd0 || s_shift !== 1'b1 || s_data !== 8'hA0 ||
        s_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got gv=%b gid=%0d shift=%b data=%h ready=%b required 1 0 1 a0 0001",
               s_gv, s_gid, s_shift, s_data, s_ready);
    end
  endtask

  task automatic test_round_robin();
    logic       es [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    logic [7:0] ed [8] = '{8'h00, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA3, 8'h00, 8'hA0};
    logic [1:0] eg [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [3:0] er [8] = '{4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    for (int c = 0; c < 8; c++) begin
      cycle();
      checks++;
      if (s_shift !== es[c] || s_gv !== es[c] || s_data !== ed[c] || s_gid !== eg[c] ||
          s_ready !== er[c]) begin
        errors++;
        $display("FAIL rr c%0d: got shift=%b gv=%b data=%h gid=%0d ready=%b required %b %b %h %0d %b",
                 c, s_shift, s_gv, s_data, s_gid, s_ready, es[c], es[c], ed[c], eg[c], er[c]);
      end
    end
    cycle();
    checks++;
    if (s_gv !== 1'b0 || s_gid !== 2'd0) begin
      errors++;
      $display("FAIL rr_final_bubble: got gv=%b gid=%0d required 0 0", s_gv, s_gid);
    end
  endtask

  task automatic test_packet_atomic();
    logic       es [7] = '{0, 1, 1, 1, 0, 1, 0};
    logic [7:0] ed [7] = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h00, 8'h05, 8'h00};
    logic [1:0] eg [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    logic [3:0] er [7] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h1, 4'h0};
    logic [2:0] eb [7] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b0);
    push(1, 8'h13, 1'b1);
    push(0, 8'h05, 1'b1);
    drive_heads();
    for (int c = 0; c < 7; c++) begin
      cycle();
      checks++;
      if (s_shift !== es[c] || s_data !== ed[c] || s_gid !== eg[c] || s_ready !== er[c] ||
          s_bb !== eb[c]) begin
        errors++;
        $display("FAIL packet c%0d: got shift=%b data=%h gid=%0d ready=%b bb=%0d required %b %h %0d %b %0d",
                 c, s_shift, s_data, s_gid, s_ready, s_bb, es[c], ed[c], eg[c], er[c], eb[c]);
      end
    end
  endtask

  task automatic test_full_stall();
    logic       es [11] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    logic       ev [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] ed [11] = '{8'h00, 8'h21, 8'h22, 8'h23, 8'h23, 8'h23, 8'h23, 8'h23,
                            8'h23, 8'h24, 8'h00};
    logic [3:0] er [11] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
    logic [2:0] eb [11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0};
    push(1, 8'h21, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h23, 1'b0);
    push(1, 8'h24, 1'b1);
    drive_heads();
    for (int c = 0; c < 11; c++) begin
      fifo_in_full = (c >= 3 && c <= 7);
      cycle();
      checks++;
      if (s_shift !== es[c] || s_gv !== ev[c] || s_data !== ed[c] || s_ready !== er[c] ||
          s_bb !== eb[c] || (c > 0 && s_gid !== 2'd1)) begin
        errors++;
        $display("FAIL full_stall c%0d: got shift=%b gv=%b data=%h ready=%b bb=%0d gid=%0d required %b %b %h %b %0d 1",
                 c, s_shift, s_gv, s_data, s_ready, s_bb, s_gid, es[c], ev[c], ed[c], er[c], eb[c]);
      end
    end
    fifo_in_full = 1'b0;
  endtask

  task automatic test_max_burst();
    logic       es [16] = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};
    logic [7:0] ed [16] = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h00, 8'h41, 8'h00,
                            8'h35, 8'h36, 8'h37, 8'h38, 8'h00, 8'h39, 8'h3A, 8'h00};
    logic [1:0] eg [16] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3,
                            2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [2:0] eb [16] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0,
                            3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd1, 3'd0};
    logic [3:0] er [16] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h0,
                            4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0};
    for (int b = 0; b < 10; b++) begin
      push(2, 8'h31 + 8'(b), (b == 9));
    end
    push(3, 8'h41, 1'b1);
    drive_heads();
    for (int c = 0; c < 16; c++) begin
      cycle();
      checks++;
      if (s_shift !== es[c] || s_gv !== es[c] || s_data !== ed[c] || s_gid !== eg[c] ||
          s_bb !== eb[c] || s_ready !== er[c]) begin
        errors++;
        $display("FAIL max_burst c%0d: got shift=%b gv=%b data=%h gid=%0d bb=%0d ready=%b required %b %b %h %0d %0d %b",
                 c, s_shift, s_gv, s_data, s_gid, s_bb, s_ready, es[c], es[c], ed[c], eg[c],
                 eb[c], er[c]);
      end
    end
  endtask

  task automatic test_timeout();
    push(0, 8'h51, 1'b0);
    push(1, 8'h61, 1'b1);
    drive_heads();
    cycle();
    checks++;
    if (s_gv !== 1'b0 || s_gid !== 2'd2) begin
      errors++;
      $display("FAIL timeout_arb: got gv=%b gid=%0d required 0 2", s_gv, s_gid);
    end
    cycle();
    checks++;
    if (s_gv !== 1'b1 || s_gid !== 2'd0 || s_shift !== 1'b1 || s_data !== 8'h51) begin
      errors++;
      $display("FAIL timeout_first_beat: got gv=%b gid=%0d shift=%b data=%h required 1 0 1 51",
               s_gv, s_gid, s_shift, s_data);
    end
`ifdef FIFO_ARB_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      cycle();
      checks++;
      if (s_gv !== 1'b1 || s_gid !== 2'd0 || s_abort !== 1'b0 || s_ready !== 4'b0001) begin
        errors++;
        $display("FAIL timeout_wait idle%0d: got gv=%b gid=%0d abort=%b ready=%b required 1 0 0 0001",
                 c, s_gv, s_gid, s_abort, s_ready);
      end
    end
    cycle();
    checks++;
    if (s_abort !== 1'b1 || s_gv !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: got abort=%b gv=%b required 1 1", s_abort, s_gv);
    end
    cycle();
    checks++;
    if (s_abort !== 1'b0 || s_gv !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: got abort=%b gv=%b required 0 0", s_abort, s_gv);
    end
    cycle();
    checks++;
    if (s_gv !== 1'b1 || s_gid !== 2'd1 || s_shift !== 1'b1 || s_data !== 8'h61) begin
      errors++;
      $display("FAIL timeout_next_grant: got gv=%b gid=%0d shift=%b data=%h required 1 1 1 61",
               s_gv, s_gid, s_shift, s_data);
    end
`else
    for (int c = 1; c <= 110; c++) begin
      cycle();
      checks++;
      if (s_gv !== 1'b1 || s_gid !== 2'd0 || s_abort !== 1'b0 || s_shift !== 1'b0 ||
          s_ready !== 4'b0001) begin
        errors++;
        $display("FAIL hold_grant idle%0d: got gv=%b gid=%0d abort=%b shift=%b ready=%b required 1 0 0 0 0001",
                 c, s_gv, s_gid, s_abort, s_shift, s_ready);
      end
    end
`endif
  endtask

  initial begin
    reset        = 1'b1;
    fifo_in_full = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      push(i, 8'hA0 + 8'(i), 1'b1);
    end
    push(0, 8'hA0, 1'b1);
    drive_heads();

    test_reset();
    test_round_robin();
    test_packet_atomic();
    test_full_stall();
    test_max_burst();
    test_timeout();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of one synchronous fifo instance (in_shift / in_data / in_full) between NUM_REQ independent producers.
- Round-robin arbitration with packet-atomic grants: a granted requester keeps the port until its last beat is accepted, or until a MAX_BURST cap forces release.
- Sits between protocol engines or host command sources and the shared command/result fifo.

Parameters:
- WIDTH, 8: data width, equal to the fifo WIDTH.
- NUM_REQ, 4: number of requesters, minimum 2.
- MAX_BURST, 16: beats accepted per grant before forced release, minimum 1.
- TIMEOUT_CYCLES, 16: idle-cycle limit for a granted requester. Used only with FIFO_ARB_TIMEOUT_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  NUM_REQ  marks the final beat of a packet.
- req_ready  out  NUM_REQ  beat accepted when req_valid[i] && req_ready[i].
- fifo_in_shift  out  1  connects to fifo in_shift.
- fifo_in_data  out  WIDTH  connects to fifo in_data.
- fifo_in_full  in  1  connects to fifo in_full.
- grant_valid  out  1  a requester currently owns the port.
- grant_id  out  IDW=max(1,$clog2(NUM_REQ))  index of the owner.
- burst_beats  out  $clog2(MAX_BURST+1)  beats accepted in the current grant.
- abort  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset, applied synchronously at any time including mid-burst:
  - grant_valid=0, grant_id=0, burst_beats=0, abort=0, req_ready=0, fifo_in_shift=0.
  - rr_ptr (last winner) = NUM_REQ-1, so requester 0 wins first.
  - Beats already written to the fifo are not flushed.
- States: IDLE, BURST. Both registered.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_REQ.
  - Next cycle: grant_id=winner, grant_valid=1, burst_beats=0, state=BURST.
  - req_last is not inspected in IDLE.
  - No request: stay in IDLE with no change.
- BURST, combinational outputs:
  - req_ready[i] = grant_valid && grant_id==i && !fifo_in_full. All other bits are 0.
  - fifo_in_shift = req_valid[grant_id] && req_ready[grant_id].
  - fifo_in_data = selected req_data slice. It is 0 when grant_valid=0.
- Accepted beat (fifo_in_shift=1): burst_beats increments.
- Release happens on an accepted beat with req_last[grant_id]=1, or when burst_beats+1 == MAX_BURST.
  - Next cycle: grant_valid=0, rr_ptr=grant_id, burst_beats=0, state=IDLE.
  - grant_id holds its last value.
- One-cycle arbitration bubble after every release. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- fifo_in_full=1 stalls the burst: no shift, burst_beats holds, grant held. Full never releases a grant.
- Granted requester deasserting valid mid-packet: grant held (see Optional Feature).
- req_valid / req_data / req_last must remain stable while valid && !ready. The arbiter does not register data.
- Requesters not granted see req_ready=0 regardless of fifo state.

Optional Feature:
- Macro: FIFO_ARB_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive BURST cycles with req_valid[grant_id]=0.
  - It resets on any cycle with valid high; cycles stalled by fifo_in_full with valid high do not count.
  - When the count reaches TIMEOUT_CYCLES, the grant is released exactly as on req_last: rr_ptr=grant_id, state=IDLE.
  - abort=1 for that single cycle, coincident with grant_valid falling.
- Not defined: no counter, abort tied to 0, TIMEOUT_CYCLES unused, and the grant is held indefinitely.

Test Plan:
1. Reset with all four req_valid=1 and last=1 -> all outputs 0 during reset. First cycle after reset deasserts: IDLE arbitrates. Next cycle: grant_id=0, grant_valid=1, fifo_in_shift=1 with req0 data.
2. NUM_REQ=4, all valid, single-beat packets (data 0xA0..0xA3) -> fifo receives A0,A1,A2,A3,A0 with one shift every 2 cycles and grant_id sequence 0,1,2,3,0.
3. req1 sends a 3-beat packet 0x11,0x12,0x13 (last on 0x13) while req0 is valid -> req_ready[0] stays 0 until 0x13 is accepted, then req0 is granted after the one-cycle bubble.
4. fifo_in_full held high 5 cycles after beat 2 of a 4-beat packet -> fifo_in_shift=0 and req_ready=0 for those 5 cycles, burst_beats stays 2, then beats 3-4 complete and the grant releases.
5. MAX_BURST=4: req2 offers 10 beats (last on beat 10) with req3 also valid -> release after beat 4, req3 served, req2 re-granted, then release again after beats 8 and 10.
6. FIFO_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: granted req0 drops valid after beat 1 -> abort=1 on the 16th idle cycle, grant_valid=0 next, req1 granted. Without the macro, grant_id stays 0 for 100+ cycles and abort stays 0.
